// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg
//   Shared definitions for the VGA timing receiver: default 640x480@60 timing
//   constants, receiver lock-state encoding and the CRC-16/CCITT step helper
//   used by the optional frame CRC.
//   No ports.
package vga_timing_pkg;

  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_H_TOTAL  = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;

  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;
  localparam int VGA_V_TOTAL  = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

  localparam logic [15:0] CRC_POLY = 16'h1021;
  localparam logic [15:0] CRC_INIT = 16'hFFFF;

  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'd0,
    ST_MEASURE  = 2'd1,
    ST_LOCKED   = 2'd2
  } rx_state_t;

  // One 12-bit pixel folded into the CRC, MSB first.
  function automatic logic [15:0] crc16_step12(input logic [15:0] crc_in,
                                               input logic [11:0] data);
    logic [15:0] c;
    c = crc_in;
    for (int i = 11; i >= 0; i--) begin
      if (c[15] ^ data[i]) c = {c[14:0], 1'b0} ^ CRC_POLY;
      else                 c = {c[14:0], 1'b0};
    end
    return c;
  endfunction

endpackage

// File: rtl/vga_rx_crc16.sv
// vga_rx_crc16
//   Running CRC-16/CCITT accumulator, one 12-bit pixel per enabled cycle.
//   clk, reset : clock, synchronous active-high reset (acc -> 0xFFFF)
//   en         : fold din into the accumulator
//   clr        : restart at 0xFFFF (wins over en)
//   din[11:0]  : pixel colour
//   crc[15:0]  : current accumulator value
module vga_rx_crc16
  import vga_timing_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        clr,
  input  logic [11:0] din,
  output logic [15:0] crc
);

  always_ff @(posedge clk) begin
    if (reset || clr) crc <= CRC_INIT;
    else if (en)      crc <= crc16_step12(crc, din);
  end

endmodule

// File: rtl/vga_timing_rx.sv
// vga_timing_rx
//   VGA sink: recovers pixel coordinates and frame timing from an
//   hsync/vsync/RGB stream, checks line and frame lengths and locks after
//   LOCK_FRAMES consecutive clean frames.
//   Optional feature macro: VGA_RX_CRC_EN adds frame_crc/crc_valid.
// Ports
//   clk, reset      : clock, synchronous active-high reset
//   pix_en          : pixel tick; every register advances only on it
//   hsync, vsync    : sync inputs, active level SYNC_ACT
//   rgb_in[11:0]    : colour {R4,G4,B4}
//   x[9:0], y[9:0]  : active-window coordinates (0 outside the window)
//   rgb_out[11:0]   : colour aligned to x/y, 0 unless pix_valid
//   pix_valid       : locked and inside the active window
//   frame_start     : pix_valid at (0,0)
//   locked          : timing lock
//   err_hlen        : one-tick pulse, bad line length
//   err_vlen        : one-tick pulse, bad frame length
//   frame_crc[15:0], crc_valid : (VGA_RX_CRC_EN) CRC of a completed locked frame
//
// state       | meaning
// ST_UNLOCKED | no timing reference yet, waiting for a vsync edge
// ST_MEASURE  | counting consecutive error-free frames
// ST_LOCKED   | LOCK_FRAMES clean frames seen, pixels are reported
module vga_timing_rx
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE    = VGA_H_ACTIVE,
  parameter int H_FP        = VGA_H_FP,
  parameter int H_SYNC      = VGA_H_SYNC,
  parameter int H_BP        = VGA_H_BP,
  parameter int V_ACTIVE    = VGA_V_ACTIVE,
  parameter int V_FP        = VGA_V_FP,
  parameter int V_SYNC      = VGA_V_SYNC,
  parameter int V_BP        = VGA_V_BP,
  parameter bit SYNC_ACT    = 1'b0,
  parameter int LOCK_FRAMES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pix_en,
  input  logic        hsync,
  input  logic        vsync,
  input  logic [11:0] rgb_in,
  output logic [9:0]  x,
  output logic [9:0]  y,
  output logic [11:0] rgb_out,
  output logic        pix_valid,
  output logic        frame_start,
  output logic        locked,
  output logic        err_hlen,
  output logic        err_vlen
`ifdef VGA_RX_CRC_EN
  ,
  output logic [15:0] frame_crc,
  output logic        crc_valid
`endif
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int H_OFS   = H_SYNC + H_BP;
  localparam int V_OFS   = V_SYNC + V_BP;

  // Sync levels are stored as "asserted" flags so reset means "not in sync".
  logic        hs_s1, hs_s2, vs_s1, vs_s2;
  logic [11:0] rgb_s1, rgb_s2;
  logic [10:0] hcnt;
  logic [9:0]  vcnt;
  logic        h_started, v_started, vs_edge_q;
  logic        hs_edge, vs_edge;
  logic [11:0] hlen;
  logic [10:0] vlen;
  rx_state_t   state, state_nxt;
  logic [7:0]  good_cnt, good_nxt;
  logic        h_in, v_in;

  assign hs_edge = hs_s1 & ~hs_s2;
  assign vs_edge = vs_s1 & ~vs_s2;
  assign hlen    = {1'b0, hcnt} + 12'd1;
  // Lines in the frame include the line whose hsync coincides with vsync.
  assign vlen    = {1'b0, vcnt} + {10'd0, hs_edge};

  always_ff @(posedge clk) begin
    if (reset) begin
      hs_s1     <= 1'b0;
      hs_s2     <= 1'b0;
      vs_s1     <= 1'b0;
      vs_s2     <= 1'b0;
      rgb_s1    <= '0;
      rgb_s2    <= '0;
      hcnt      <= '0;
      vcnt      <= '0;
      h_started <= 1'b0;
      v_started <= 1'b0;
      vs_edge_q <= 1'b0;
      err_hlen  <= 1'b0;
      err_vlen  <= 1'b0;
    end else if (pix_en) begin
      hs_s1     <= (hsync == SYNC_ACT);
      hs_s2     <= hs_s1;
      vs_s1     <= (vsync == SYNC_ACT);
      vs_s2     <= vs_s1;
      rgb_s1    <= rgb_in;
      rgb_s2    <= rgb_s1;
      if (hs_edge)                hcnt <= '0;
      else if (hcnt != 11'h7FF)   hcnt <= hcnt + 11'd1;
      if (vs_edge)                vcnt <= '0;
      else if (hs_edge && vcnt != 10'h3FF) vcnt <= vcnt + 10'd1;
      // The first edge after reset only establishes a reference.
      err_hlen  <= hs_edge & h_started & (hlen != 12'(H_TOTAL));
      err_vlen  <= vs_edge & v_started & (vlen != 11'(V_TOTAL));
      vs_edge_q <= vs_edge;
      if (hs_edge) h_started <= 1'b1;
      if (vs_edge) v_started <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_UNLOCKED;
      good_cnt <= '0;
    end else if (pix_en) begin
      state    <= state_nxt;
      good_cnt <= good_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    good_nxt  = good_cnt;
    case (state)
      ST_UNLOCKED: begin
        if (vs_edge_q) begin
          state_nxt = ST_MEASURE;
          good_nxt  = '0;
        end
      end
      ST_MEASURE: begin
        if (err_hlen || err_vlen) begin
          state_nxt = ST_UNLOCKED;
          good_nxt  = '0;
        end else if (vs_edge_q) begin
          good_nxt = good_cnt + 8'd1;
          if (good_cnt + 8'd1 >= 8'(LOCK_FRAMES)) state_nxt = ST_LOCKED;
        end
      end
      ST_LOCKED: begin
        if (err_hlen || err_vlen) begin
          state_nxt = ST_UNLOCKED;
          good_nxt  = '0;
        end
      end
      default: begin
        state_nxt = ST_UNLOCKED;
        good_nxt  = '0;
      end
    endcase
  end

  assign locked = (state == ST_LOCKED);
  assign h_in   = (hcnt >= 11'(H_OFS)) && (hcnt < 11'(H_OFS + H_ACTIVE));
  assign v_in   = (vcnt >= 10'(V_OFS)) && (vcnt < 10'(V_OFS + V_ACTIVE));

  always_comb begin
    x           = '0;
    y           = '0;
    pix_valid   = 1'b0;
    rgb_out     = '0;
    frame_start = 1'b0;
    if (h_in && v_in) begin
      x = 10'(hcnt - 11'(H_OFS));
      y = vcnt - 10'(V_OFS);
    end
    pix_valid   = locked & h_in & v_in;
    if (pix_valid) rgb_out = rgb_s2;
    frame_start = pix_valid && (x == 10'd0) && (y == 10'd0);
  end

`ifdef VGA_RX_CRC_EN
  logic [15:0] crc_acc;

  // The vsync edge both closes the previous frame and restarts the CRC.
  vga_rx_crc16 u_crc (
    .clk   (clk),
    .reset (reset),
    .en    (pix_en & pix_valid),
    .clr   (pix_en & vs_edge_q),
    .din   (rgb_out),
    .crc   (crc_acc)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      frame_crc <= '0;
      crc_valid <= 1'b0;
    end else if (pix_en) begin
      crc_valid <= vs_edge_q & locked;
      if (vs_edge_q && locked) frame_crc <= crc_acc;
    end
  end
`endif

endmodule
